// File: rtl/spi_rdid_slave.sv
// SPI mode-0 responder for the RDID command: oversamples the SPI pins, decodes the opcode and
// streams {manufacturer, memory type, capacity} MSB-first. Define SPI_TRISTATE_MISO_EN to float MISO.
`timescale 1ns / 1ps

module spi_rdid_slave #(
   parameter logic [7:0]  MANUFACTURER_ID = 8'h20,
   parameter logic [7:0]  MEMORY_TYPE     = 8'h20,
   parameter logic [7:0]  MEMORY_CAPACITY = 8'h18,
   parameter logic [7:0]  RDID_CMD        = 8'h9F,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       SPICLK,
   input  logic       chip_select,
   input  logic       SPIMOSI,
   output logic       SPIMISO,
   output logic [7:0] cmd_byte,
   output logic       cmd_valid,
   output logic       rdid_done,
   output logic       busy
);

   typedef enum logic [1:0] {StIdle, StCmd, StResp, StIgnore} state_e;

   localparam logic [23:0] IdWord = {MANUFACTURER_ID, MEMORY_TYPE, MEMORY_CAPACITY};

   logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic                   sclk_dly_q, cs_dly_q;
   logic                   sclk_s, cs_s, mosi_s;
   logic                   sclk_rise, sclk_fall, cs_fall;

   state_e      state_q, state_d;
   logic [7:0]  shift_q, shift_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [23:0] resp_q, resp_d;
   logic [7:0]  cmd_byte_q, cmd_byte_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic        rdid_done_q, rdid_done_d;

   // Synchronizers reset to the idle bus levels so a held-low select shows up as a fresh start.
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_dly_q  <= 1'b0;
         cs_dly_q    <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPICLK};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], chip_select};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPIMOSI};
         sclk_dly_q  <= sclk_s;
         cs_dly_q    <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_dly_q;
   assign sclk_fall = ~sclk_s & sclk_dly_q;
   assign cs_fall   = ~cs_s & cs_dly_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         shift_q     <= 8'h00;
         bit_cnt_q   <= 5'd0;
         resp_q      <= 24'h000000;
         cmd_byte_q  <= 8'h00;
         cmd_valid_q <= 1'b0;
         rdid_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         resp_q      <= resp_d;
         cmd_byte_q  <= cmd_byte_d;
         cmd_valid_q <= cmd_valid_d;
         rdid_done_q <= rdid_done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      resp_d      = resp_q;
      cmd_byte_d  = cmd_byte_q;
      cmd_valid_d = 1'b0;
      rdid_done_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cs_fall) begin
               state_d   = StCmd;
               shift_d   = 8'h00;
               bit_cnt_d = 5'd0;
            end
         end
         StCmd: begin
            if (cs_s) begin
               state_d = StIdle;
            end else if (bit_cnt_q == 5'd8) begin
               cmd_byte_d  = shift_q;
               cmd_valid_d = 1'b1;
               if (shift_q == RDID_CMD) begin
                  state_d   = StResp;
                  resp_d    = IdWord;
                  bit_cnt_d = 5'd0;
               end else begin
                  state_d = StIgnore;
               end
            end else if (sclk_rise) begin
               shift_d   = {shift_q[6:0], mosi_s};
               bit_cnt_d = bit_cnt_q + 5'd1;
            end
         end
         StResp: begin
            if (cs_s) begin
               state_d = StIdle;
            end else if (sclk_rise) begin
               bit_cnt_d = bit_cnt_q + 5'd1;
            end else if (sclk_fall && (bit_cnt_q != 5'd0)) begin
               // A fall with no rise since the load (the opcode's last fall) must not consume bit 23.
               if (bit_cnt_q == 5'd24) begin
                  resp_d      = IdWord;
                  bit_cnt_d   = 5'd0;
                  rdid_done_d = 1'b1;
               end else begin
                  resp_d = {resp_q[22:0], 1'b0};
               end
            end
         end
         StIgnore: begin
            if (cs_s) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef SPI_TRISTATE_MISO_EN
   assign SPIMISO = (state_q == StResp) ? resp_q[23] : 1'bz;
`else
   assign SPIMISO = (state_q == StResp) ? resp_q[23] : 1'b0;
`endif

   assign cmd_byte  = cmd_byte_q;
   assign cmd_valid = cmd_valid_q;
   assign rdid_done = rdid_done_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_spi_rdid_slave.sv
// Directed bench for spi_rdid_slave: an SPI master model drives transactions and a reference
// of the expected ID bit stream and pulse counts is checked against the DUT.
`timescale 1ns / 1ps

module tb_spi_rdid_slave;

   localparam int          Half   = 8;
   localparam logic [23:0] IdRef  = {8'h20, 8'h20, 8'h18};
   localparam logic [7:0]  RdidOp = 8'h9F;
`ifdef SPI_TRISTATE_MISO_EN
   localparam logic QuietMiso = 1'bz;
`else
   localparam logic QuietMiso = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, SPICLK, chip_select, SPIMOSI;
   wire        SPIMISO;
   logic [7:0] cmd_byte;
   logic       cmd_valid, rdid_done, busy;

   int         vectors = 0;
   int         miscompares = 0;
   int         n_valid = 0;
   int         n_done = 0;
   logic [7:0] exp_cmd = 8'h00;
   bit         exp_quiet = 1'b0;

   spi_rdid_slave dut (
      .clk        (clk),
      .reset      (reset),
      .SPICLK     (SPICLK),
      .chip_select(chip_select),
      .SPIMOSI    (SPIMOSI),
      .SPIMISO    (SPIMISO),
      .cmd_byte   (cmd_byte),
      .cmd_valid  (cmd_valid),
      .rdid_done  (rdid_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Expected master-side sample stream: the 24-bit ID, MSB first, repeating.
   function automatic logic [63:0] exp_bits(input int n);
      logic [63:0] r = '0;
      for (int i = 0; i < n; i++) r = {r[62:0], IdRef[23 - (i % 24)]};
      return r;
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         if (cmd_valid) begin
            n_valid++;
            chk("cmd_byte_at_valid", {56'b0, cmd_byte}, {56'b0, exp_cmd});
         end
         if (rdid_done) n_done++;
         if (!busy || exp_quiet) chk("miso_quiet", {63'b0, SPIMISO}, {63'b0, QuietMiso});
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [7:0] b, input int nbits);
      for (int i = 7; i >= 8 - nbits; i--) begin
         SPIMOSI = b[i];
         wait_clk(Half);
         SPICLK = 1'b1;
         wait_clk(Half);
         SPICLK = 1'b0;
      end
   endtask

   task automatic resp_clocks(input int n, output logic [63:0] got);
      got = '0;
      for (int i = 0; i < n; i++) begin
         wait_clk(Half);
         got = {got[62:0], SPIMISO};
         SPICLK = 1'b1;
         wait_clk(Half);
         SPICLK = 1'b0;
      end
   endtask

   task automatic cs_low();
      chip_select = 1'b0;
      wait_clk(Half);
   endtask

   task automatic cs_high();
      wait_clk(Half);
      chip_select = 1'b1;
      wait_clk(Half);
   endtask

   task automatic rdid(input int nresp, output logic [63:0] got);
      int v0 = n_valid;
      int d0 = n_done;
      exp_cmd = RdidOp;
      cs_low();
      send_bits(RdidOp, 8);
      resp_clocks(nresp, got);
      cs_high();
      chk("rdid_bits", got, exp_bits(nresp));
      chk("rdid_valid_cnt", 64'(n_valid - v0), 64'd1);
      chk("rdid_done_cnt", 64'(n_done - d0), 64'(nresp / 24));
      chk("rdid_busy_after", {63'b0, busy}, 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [63:0] got;
      int v0, d0;
      reset = 1'b1;
      SPICLK = 1'b0;
      chip_select = 1'b1;
      SPIMOSI = 1'b0;
      wait_clk(5);
      chk("rst_miso", {63'b0, SPIMISO}, {63'b0, QuietMiso});
      chk("rst_busy", {63'b0, busy}, 64'd0);
      chk("rst_cmd_valid", {63'b0, cmd_valid}, 64'd0);
      chk("rst_rdid_done", {63'b0, rdid_done}, 64'd0);
      chk("rst_cmd_byte", {56'b0, cmd_byte}, 64'h00);
      reset = 1'b0;
      wait_clk(5);

      // Plain RDID.
      rdid(24, got);
      chk("id_literal", got, 64'h202018);
      chk("cmd_byte_held", {56'b0, cmd_byte}, 64'h9F);

      // Non-RDID opcode: line stays quiet, no done pulse.
      v0 = n_valid;
      d0 = n_done;
      exp_cmd = 8'h03;
      exp_quiet = 1'b1;
      cs_low();
      send_bits(8'h03, 8);
      resp_clocks(24, got);
      cs_high();
      exp_quiet = 1'b0;
`ifndef SPI_TRISTATE_MISO_EN
      chk("ignore_bits", got, 64'h0);
`endif
      chk("ignore_valid_cnt", 64'(n_valid - v0), 64'd1);
      chk("ignore_done_cnt", 64'(n_done - d0), 64'd0);
      chk("ignore_cmd_byte", {56'b0, cmd_byte}, 64'h03);

      // Aborted response after 12 bits, then a clean RDID.
      v0 = n_valid;
      d0 = n_done;
      exp_cmd = RdidOp;
      cs_low();
      send_bits(RdidOp, 8);
      resp_clocks(12, got);
      cs_high();
      chk("abort_bits", got, 64'h202);
      chk("abort_valid_cnt", 64'(n_valid - v0), 64'd1);
      chk("abort_done_cnt", 64'(n_done - d0), 64'd0);
      chk("abort_busy", {63'b0, busy}, 64'd0);
      rdid(24, got);
      chk("after_abort_literal", got, 64'h202018);

      // ID repeats under continued clocking.
      rdid(48, got);
      chk("repeat_literal", got, 64'h202018202018);

      // Reset mid-command with select held low; the held-low select restarts a transaction.
      v0 = n_valid;
      exp_cmd = 8'hA5;
      cs_low();
      send_bits(8'hA5, 4);
      reset = 1'b1;
      wait_clk(4);
      chk("midrst_busy", {63'b0, busy}, 64'd0);
      chk("midrst_cmd_byte", {56'b0, cmd_byte}, 64'h00);
      reset = 1'b0;
      wait_clk(Half);
      chk("midrst_restart_busy", {63'b0, busy}, 64'd1);
      chk("midrst_no_valid", 64'(n_valid - v0), 64'd0);
      d0 = n_done;
      exp_cmd = RdidOp;
      send_bits(RdidOp, 8);
      resp_clocks(24, got);
      cs_high();
      chk("midrst_bits", got, 64'h202018);
      chk("midrst_valid_cnt", 64'(n_valid - v0), 64'd1);
      chk("midrst_done_cnt", 64'(n_done - d0), 64'd1);

      wait_clk(4);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spi_rdid_slave.md
Name: spi_rdid_slave

Overview:
- SPI mode-0 responder for the RDID (0x9F) read-identification command.
- Acts as the flash-side counterpart of the SPI master in the board bring-up and bench environment.
- Runs on a single system clock and oversamples SPICLK, chip_select and SPIMOSI through synchronizers.
- Decodes the 8-bit command and shifts out a 24-bit ID {manufacturer, memory type, capacity} MSB-first on SPIMISO.

Parameters:
- MANUFACTURER_ID, 8'h20, first response byte.
- MEMORY_TYPE, 8'h20, second response byte.
- MEMORY_CAPACITY, 8'h18, third response byte.
- RDID_CMD, 8'h9F, command opcode that triggers the ID response.
- SYNC_STAGES, 2, flip-flop stages per synchronized input (legal range 2..3).

Ports:
- clk  in  1  system clock; every register is clocked on its rising edge.
- reset  in  1  synchronous, active-high reset.
- SPICLK  in  1  SPI clock from the master; idles low (mode 0).
- chip_select  in  1  active-low slave select.
- SPIMOSI  in  1  serial command data from the master.
- SPIMISO  out  1  serial response data to the master.
- cmd_byte  out  8  last fully received command byte.
- cmd_valid  out  1  one-clk pulse when cmd_byte updates.
- rdid_done  out  1  one-clk pulse at each completed 24-bit ID transfer.
- busy  out  1  high while the state is not IDLE.

Behaviour:
- Reset (synchronous, in clk): state=IDLE, SPIMISO=0, cmd_byte=8'h00, cmd_valid=0, rdid_done=0, busy=0. Synchronizer flops load their idle values: SPICLK=0, chip_select=1, SPIMOSI=0.
- Input conditioning: each input passes through SPI_SYNC_STAGES flops. Edge detect compares the last synchronized stage with a one-cycle-delayed copy. Edge-to-action latency is SYNC_STAGES+1 clk.
- Legal operation requires each SPICLK high and low phase to last at least SYNC_STAGES+2 clk. Faster SPICLK is out of spec.
- States: IDLE, CMD, RESP, IGNORE.
- IDLE: on a synchronized chip_select falling edge, go to CMD. Clear the shift-in register and set bit_cnt=0.
- CMD: on each synchronized SPICLK rising edge, shift SPIMOSI into the LSB (MSB received first) and increment bit_cnt.
  - After the 8th bit, on the following clk: cmd_byte = the received byte, and cmd_valid pulses for one clk.
  - If the byte equals RDID_CMD: go to RESP, load resp_sr={MANUFACTURER_ID,MEMORY_TYPE,MEMORY_CAPACITY}, drive SPIMISO=resp_sr[23] immediately, and clear bit_cnt.
  - Otherwise: go to IGNORE.
- RESP:
  - On each synchronized SPICLK rising edge, increment bit_cnt (0..23).
  - On each synchronized SPICLK falling edge, shift resp_sr left by 1 so that SPIMISO=resp_sr[23].
  - On the falling edge that follows the 24th rising edge: pulse rdid_done for one clk, reload resp_sr, set SPIMISO=MANUFACTURER_ID[7], and clear bit_cnt. The ID therefore repeats while clocking continues.
- IGNORE: SPIMISO=0, SPICLK edges are ignored, and no pulses are generated.
- From any non-IDLE state, a synchronized chip_select high returns to IDLE within 1 clk. In IDLE: SPIMISO=0, and any partial command or response is discarded without a cmd_valid or rdid_done pulse.
- Simultaneous events:
  - chip_select deassert and an SPICLK edge detected in the same clk: the deassert wins and the edge is ignored.
  - reset overrides everything.
- Reset while chip_select is still low: after reset the block stays in IDLE until a fresh chip_select falling edge. Because the synchronizer resets to 1, a held-low chip_select appears as a falling edge once reset is released. That edge is treated as a new transaction start.
- Width rules:
  - bit_cnt is 5 bits. It saturates at 8 in CMD and wraps to 0 after 24 in RESP.
  - cmd_byte is held until the next complete command.

Optional Feature:
- Macro: SPI_TRISTATE_MISO_EN.
- Defined: SPIMISO is driven 1'bz in IDLE and IGNORE and driven only in RESP, so several slaves can share the line. Reset value is 1'bz.
- Not defined: SPIMISO is driven to 0 whenever the block is not in RESP, and the reset value is 0.

Test Plan:
- Reset with chip_select=1 -> SPIMISO=0, busy=0, cmd_valid=0, rdid_done=0, cmd_byte=8'h00.
- chip_select low, shift 8'h9F, then 24 SPICLK cycles (half period 8 clk) -> cmd_valid pulses once with cmd_byte=8'h9F. Bits sampled on SPICLK rising edges read 24'h202018. rdid_done pulses once, then chip_select high returns busy=0.
- Shift command 8'h03 followed by 24 clocks -> cmd_valid pulses with 8'h03. SPIMISO stays 0 (1'bz with SPI_TRISTATE_MISO_EN). rdid_done never pulses.
- RDID, then chip_select raised after 12 response bits -> IDLE with no rdid_done pulse. The next full RDID returns 24'h202018 starting from bit 23.
- RDID with 48 response clocks -> 48'h202018202018 sampled, and rdid_done pulses twice.
- reset asserted after 4 command bits with chip_select held low -> IDLE with no cmd_valid pulse. After release, a full 0x9F sequence yields the correct ID.
